slv_i2c_reg_fsm: RTL and testbench

Parametrised I2C slave controller FSM with own-address match, repeated-START support and a register-pointer protocol for burst access to an external register bank of REG_NUM words. It sits behind the SCL/SDA synchroniser and edge detector, consuming the same edge and mid-low strobes. It drives the open-drain SDA request and a single-cycle write strobe and read address toward the register bank. It adds three things beyond single-byte command/data handling: address filtering, pointer auto-increment with wrap, and NACK of out-of-range pointers.

---
 rtl/slv_i2c_reg_fsm_if.sv | 40 ++++
 rtl/slv_i2c_reg_fsm.sv | 201 ++++++++++++++++++++
 tb/tb_slv_i2c_reg_fsm.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/slv_i2c_reg_fsm_if.sv
// Bus-side bundle of the I2C register slave: synchronised SCL/SDA levels and
// strobes in, open-drain SDA request and register-bank access out.
interface slv_i2c_reg_fsm_if #(
  parameter int DATA_SZ = 8,
  parameter int REG_NUM = 16
);
  localparam int PTR_SZ = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  logic               I_SCL;
  logic               I_SDA;
  logic               I_RS_IO_SCL;
  logic               I_FL_IO_SCL;
  logic               I_RS_IO_SDA;
  logic               I_FL_IO_SDA;
  logic               I_MDL_LW_IO_SCL;
  logic [DATA_SZ-1:0] I_REG_RDATA;

  logic               O_SDA;
  logic               O_BUSY;
  logic               O_ADDR_MATCH;
  logic               O_RW;
  logic [PTR_SZ-1:0]  O_REG_ADDR;
  logic [DATA_SZ-1:0] O_REG_WDATA;
  logic               O_REG_WE;
  logic               O_ACK_MSTR;

  modport slave (
    input  I_SCL, I_SDA, I_RS_IO_SCL, I_FL_IO_SCL, I_RS_IO_SDA, I_FL_IO_SDA,
           I_MDL_LW_IO_SCL, I_REG_RDATA,
    output O_SDA, O_BUSY, O_ADDR_MATCH, O_RW, O_REG_ADDR, O_REG_WDATA,
           O_REG_WE, O_ACK_MSTR
  );

  modport master (
    output I_SCL, I_SDA, I_RS_IO_SCL, I_FL_IO_SCL, I_RS_IO_SDA, I_FL_IO_SDA,
           I_MDL_LW_IO_SCL, I_REG_RDATA,
    input  O_SDA, O_BUSY, O_ADDR_MATCH, O_RW, O_REG_ADDR, O_REG_WDATA,
           O_REG_WE, O_ACK_MSTR
  );
endinterface

// File: rtl/slv_i2c_reg_fsm.sv
// I2C slave controller: own-address filter, register-pointer byte, burst
// write/read with pointer auto-increment and wrap, NACK of bad pointers.
module slv_i2c_reg_fsm #(
  parameter int                 DATA_SZ  = 8,
  parameter logic [DATA_SZ-2:0] ADDR_SLV = 7'h50,
  parameter int                 REG_NUM  = 16
) (
  input  logic              CLK,
  input  logic              RST_n,
  slv_i2c_reg_fsm_if.slave  bus
);
  localparam int PTR_SZ = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
  localparam int CNT_SZ = $clog2(DATA_SZ + 1);
  localparam logic [CNT_SZ-1:0] BITS     = CNT_SZ'(DATA_SZ);
  localparam logic [PTR_SZ-1:0] PTR_LAST = PTR_SZ'(REG_NUM - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_COMM, S_ACK_COMM, S_IGNORE, S_PTR, S_ACK_PTR,
    S_RX, S_ACK_RX, S_TX, S_MSTR_ACK
  } state_e;

  state_e             state_q;
  logic [CNT_SZ-1:0]  cnt_q;
  logic [DATA_SZ-1:0] shift_q;
  logic               byte_done_q;
  logic               inc_pend_q;
  logic               sda_q;
  logic               busy_q;
  logic               match_q;
  logic               rw_q;
  logic [PTR_SZ-1:0]  ptr_q;
  logic [DATA_SZ-1:0] wdata_q;
  logic               we_q;
  logic               ack_mstr_q;

  logic               start_det;
  logic               stop_det;
  logic               scl_rise;
  logic               mid_low;
  logic [DATA_SZ-1:0] rx_byte;
  logic               addr_hit;
  logic               ptr_ok;
  logic [PTR_SZ-1:0]  ptr_next;

  assign start_det = bus.I_FL_IO_SDA & bus.I_SCL;
  assign stop_det  = bus.I_RS_IO_SDA & bus.I_SCL;
  assign scl_rise  = bus.I_RS_IO_SCL;
  assign mid_low   = bus.I_MDL_LW_IO_SCL;
  assign rx_byte   = {shift_q[DATA_SZ-2:0], bus.I_SDA};
  assign addr_hit  = (rx_byte[DATA_SZ-1:1] == ADDR_SLV);
  assign ptr_ok    = (32'(rx_byte) < 32'(REG_NUM));
  assign ptr_next  = (ptr_q == PTR_LAST) ? '0 : ptr_q + 1'b1;

  // Byte-receiving states hand over to their own ACK state.
  function automatic state_e ack_state(input state_e s);
    case (s)
      S_COMM:  return S_ACK_COMM;
      S_PTR:   return S_ACK_PTR;
      default: return S_ACK_RX;
    endcase
  endfunction

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // below sees the value from before this clock edge regardless of order.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      shift_q     <= '0;
      byte_done_q <= 1'b0;
      inc_pend_q  <= 1'b0;
      sda_q       <= 1'b1;
      busy_q      <= 1'b0;
      match_q     <= 1'b0;
      rw_q        <= 1'b0;
      ptr_q       <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      ack_mstr_q  <= 1'b0;
    end else begin
      we_q <= 1'b0;
      if (inc_pend_q) begin
        inc_pend_q <= 1'b0;
        ptr_q      <= ptr_next;
      end

      if (start_det) begin
        state_q     <= S_COMM;
        busy_q      <= 1'b1;
        match_q     <= 1'b0;
        cnt_q       <= BITS;
        sda_q       <= 1'b1;
        byte_done_q <= 1'b0;
      end else if (stop_det && state_q != S_IDLE) begin
        state_q     <= S_IDLE;
        busy_q      <= 1'b0;
        match_q     <= 1'b0;
        sda_q       <= 1'b1;
        byte_done_q <= 1'b0;
      end else begin
        case (state_q)
          S_COMM, S_PTR, S_RX: begin
            if (scl_rise && !byte_done_q) begin
              shift_q <= rx_byte;
              cnt_q   <= cnt_q - 1'b1;
              if (cnt_q == CNT_SZ'(1)) begin
                byte_done_q <= 1'b1;
                if (state_q == S_COMM) begin
                  if (addr_hit) rw_q <= rx_byte[0];
                  else begin
                    state_q     <= S_IGNORE;
                    byte_done_q <= 1'b0;
                  end
                end else if (state_q == S_PTR) begin
                  if (ptr_ok) ptr_q <= rx_byte[PTR_SZ-1:0];
                  else begin
                    state_q     <= S_IGNORE;
                    byte_done_q <= 1'b0;
                  end
                end else begin
                  wdata_q    <= rx_byte;
                  we_q       <= 1'b1;
                  inc_pend_q <= 1'b1;
                end
              end
            end else if (mid_low && byte_done_q) begin
              sda_q       <= 1'b0;
              byte_done_q <= 1'b0;
              state_q     <= ack_state(state_q);
            end
          end
          S_ACK_COMM: begin
            if (mid_low) begin
              match_q <= 1'b1;
              cnt_q   <= BITS;
              if (!rw_q) begin
                sda_q   <= 1'b1;
                state_q <= S_PTR;
              end else begin
                shift_q <= bus.I_REG_RDATA;
                sda_q   <= bus.I_REG_RDATA[DATA_SZ-1];
                state_q <= S_TX;
              end
            end
          end
          S_ACK_PTR, S_ACK_RX: begin
            if (mid_low) begin
              sda_q   <= 1'b1;
              cnt_q   <= BITS;
              state_q <= S_RX;
            end
          end
          S_TX: begin
            if (scl_rise) begin
              cnt_q <= cnt_q - 1'b1;
            end else if (mid_low) begin
              if (cnt_q == '0) begin
                sda_q       <= 1'b1;
                ptr_q       <= ptr_next;
                byte_done_q <= 1'b0;
                state_q     <= S_MSTR_ACK;
              end else begin
                // Rotating keeps the whole byte in place after DATA_SZ shifts.
                sda_q   <= shift_q[DATA_SZ-2];
                shift_q <= {shift_q[DATA_SZ-2:0], shift_q[DATA_SZ-1]};
              end
            end
          end
          S_MSTR_ACK: begin
            if (scl_rise) begin
              ack_mstr_q  <= bus.I_SDA;
              byte_done_q <= 1'b1;
            end else if (mid_low && byte_done_q) begin
              byte_done_q <= 1'b0;
              if (!ack_mstr_q) begin
                shift_q <= bus.I_REG_RDATA;
                sda_q   <= bus.I_REG_RDATA[DATA_SZ-1];
                cnt_q   <= BITS;
                state_q <= S_TX;
              end else begin
                sda_q   <= 1'b1;
                state_q <= S_IGNORE;
              end
            end
          end
          S_IDLE, S_IGNORE: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.O_SDA        = sda_q;
  assign bus.O_BUSY       = busy_q;
  assign bus.O_ADDR_MATCH = match_q;
  assign bus.O_RW         = rw_q;
  assign bus.O_REG_ADDR   = ptr_q;
  assign bus.O_REG_WDATA  = wdata_q;
  assign bus.O_REG_WE     = we_q;
  assign bus.O_ACK_MSTR   = ack_mstr_q;
endmodule

// File: tb/tb_slv_i2c_reg_fsm.sv
// Randomised bench: a bit-level I2C master drives the slave while a
// transaction-level model of pointer and register contents predicts results.
module tb_slv_i2c_reg_fsm;
  localparam int DW = 8;
  localparam int RN = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  slv_i2c_reg_fsm_if #(.DATA_SZ(DW), .REG_NUM(RN)) bus_if ();

  slv_i2c_reg_fsm #(.DATA_SZ(DW), .ADDR_SLV(7'h50), .REG_NUM(RN)) dut (
    .CLK   (clk),
    .RST_n (rst_n),
    .bus   (bus_if)
  );

  // Master levels, synchroniser/edge detector and the register bank.
  logic m_scl = 1'b1, m_sda = 1'b1, mid = 1'b0;
  logic scl_s = 1'b1, scl_p = 1'b1, sda_s = 1'b1, sda_p = 1'b1;
  logic [DW-1:0] bank [RN] = '{default: '0};
  logic [DW-1:0] rdata_q = '0;

  always @(posedge clk) begin
    scl_s   <= m_scl;
    sda_s   <= m_sda & bus_if.O_SDA;
    scl_p   <= scl_s;
    sda_p   <= sda_s;
    rdata_q <= bank[bus_if.O_REG_ADDR];
    if (bus_if.O_REG_WE) bank[bus_if.O_REG_ADDR] <= bus_if.O_REG_WDATA;
  end

  assign bus_if.I_SCL           = scl_s;
  assign bus_if.I_SDA           = sda_s;
  assign bus_if.I_RS_IO_SCL     = scl_s & ~scl_p;
  assign bus_if.I_FL_IO_SCL     = ~scl_s & scl_p;
  assign bus_if.I_RS_IO_SDA     = sda_s & ~sda_p;
  assign bus_if.I_FL_IO_SDA     = ~sda_s & sda_p;
  assign bus_if.I_MDL_LW_IO_SCL = mid;
  assign bus_if.I_REG_RDATA     = rdata_q;

  // Observed write strobes and count of cycles with SDA pulled low.
  logic [11:0] obs_we [$];
  int sda_low = 0;
  always @(negedge clk) begin
    if (bus_if.O_REG_WE) obs_we.push_back({bus_if.O_REG_ADDR, bus_if.O_REG_WDATA});
    if (!bus_if.O_SDA) sda_low <= sda_low + 1;
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [RN] = '{default: '0};
  int            ref_ptr = 0;
  logic          ref_rw  = 1'b0;
  logic [11:0]   exp_we [$];
  logic [DW-1:0] wr_q [$];

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One SCL period: 10 CLK low with a mid-low strobe, 10 CLK high.
  task automatic clk_bit(input logic b, output logic rd);
    wait_clk(1); m_scl = 1'b0;
    wait_clk(2); m_sda = b;
    wait_clk(3); mid = 1'b1;
    wait_clk(1); mid = 1'b0;
    wait_clk(4); m_scl = 1'b1;
    wait_clk(5); rd = sda_s;
    wait_clk(5);
  endtask

  // START is (1,0), STOP is (0,1): SDA level set while SCL low, then flipped while high.
  task automatic bus_cond(input logic first, input logic second);
    wait_clk(1); m_scl = 1'b0;
    wait_clk(2); m_sda = first;
    wait_clk(3); mid = 1'b1;
    wait_clk(1); mid = 1'b0;
    wait_clk(4); m_scl = 1'b1;
    wait_clk(5); m_sda = second;
    wait_clk(5);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic ack);
    logic r;
    for (int i = 7; i >= 0; i--) clk_bit(d[i], r);
    clk_bit(1'b1, ack);
  endtask

  task automatic recv_byte(input logic mack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, r);
      d[i] = r;
    end
    clk_bit(mack, r);
  endtask

  task automatic end_checks(input int base);
    check("busy_after_stop", bus_if.O_BUSY, 0);
    check("match_after_stop", bus_if.O_ADDR_MATCH, 0);
    check("sda_after_stop", bus_if.O_SDA, 1);
    check("reg_addr", bus_if.O_REG_ADDR, ref_ptr);
    check("rw", bus_if.O_RW, ref_rw);
    check("we_count", obs_we.size() - base, exp_we.size());
    for (int i = 0; i < exp_we.size() && base + i < obs_we.size(); i++)
      check("we_event", obs_we[base + i], exp_we[i]);
    exp_we.delete();
  endtask

  // Write transaction: address a, pointer p, then every byte in wr_q.
  task automatic do_write(input logic [6:0] a, input logic [7:0] p);
    logic ack, hit, pok;
    int base, low0;
    base = obs_we.size();
    bus_cond(1'b1, 1'b0);
    check("busy_start", bus_if.O_BUSY, 1);
    low0 = sda_low;
    hit  = (a == 7'h50);
    send_byte({a, 1'b0}, ack);
    check("addr_ack", ack, !hit);
    if (hit) ref_rw = 1'b0;
    send_byte(p, ack);
    pok = hit && (int'(p) < RN);
    check("ptr_ack", ack, !pok);
    check("addr_match", bus_if.O_ADDR_MATCH, hit);
    if (pok) ref_ptr = int'(p);
    foreach (wr_q[i]) begin
      send_byte(wr_q[i], ack);
      check("data_ack", ack, !pok);
      if (pok) begin
        exp_we.push_back({4'(ref_ptr), wr_q[i]});
        ref_mem[ref_ptr] = wr_q[i];
        ref_ptr = (ref_ptr + 1) % RN;
      end
    end
    wr_q.delete();
    if (!hit) check("sda_released", sda_low - low0, 0);
    bus_cond(1'b0, 1'b1);
    end_checks(base);
  endtask

  // Read transaction of n bytes, optionally setting the pointer first via Sr.
  task automatic do_read(input logic set_ptr, input logic [7:0] p, input int n);
    logic ack;
    logic [7:0] d;
    int base;
    base = obs_we.size();
    bus_cond(1'b1, 1'b0);
    if (set_ptr) begin
      send_byte(8'hA0, ack);
      check("addr_ack", ack, 0);
      send_byte(p, ack);
      check("ptr_ack", ack, 0);
      ref_ptr = int'(p);
      bus_cond(1'b1, 1'b0);
    end
    send_byte(8'hA1, ack);
    check("raddr_ack", ack, 0);
    ref_rw = 1'b1;
    for (int k = 0; k < n; k++) begin
      recv_byte(k == n - 1, d);
      check("rd_data", d, ref_mem[ref_ptr]);
      ref_ptr = (ref_ptr + 1) % RN;
    end
    bus_cond(1'b0, 1'b1);
    check("ack_mstr", bus_if.O_ACK_MSTR, 1);
    end_checks(base);
  endtask

  initial begin
    logic ack, r;
    int base;

    wait_clk(3);
    check("rst_sda", bus_if.O_SDA, 1);
    check("rst_busy", bus_if.O_BUSY, 0);
    check("rst_match", bus_if.O_ADDR_MATCH, 0);
    check("rst_addr", bus_if.O_REG_ADDR, 0);
    check("rst_we", bus_if.O_REG_WE, 0);
    check("rst_ack_mstr", bus_if.O_ACK_MSTR, 0);
    rst_n = 1'b1;
    wait_clk(5);

    // Burst write at pointer 3.
    wr_q = '{8'h11, 8'h22};
    do_write(7'h50, 8'h03);

    // Foreign address 0xA4 followed by two bytes.
    wr_q = '{8'h77};
    do_write(7'h52, 8'h01);

    // Write across the wrap, then read it back through a repeated START.
    wr_q = '{8'h5A, 8'hC3};
    do_write(7'h50, 8'h0F);
    do_read(1'b1, 8'h0F, 2);

    // Out-of-range pointer.
    wr_q = '{8'h99};
    do_write(7'h50, 8'h10);

    // STOP after four bits of a data byte, then a normal write.
    base = obs_we.size();
    bus_cond(1'b1, 1'b0);
    send_byte(8'hA0, ack);
    send_byte(8'h05, ack);
    ref_ptr = 5;
    ref_rw  = 1'b0;
    for (int i = 0; i < 4; i++) clk_bit(1'b0, r);
    bus_cond(1'b0, 1'b1);
    end_checks(base);
    wr_q = '{8'h3C};
    do_write(7'h50, 8'h05);

    // Reset while the slave drives a 0 bit of reg[15] (0x5A).
    bus_cond(1'b1, 1'b0);
    send_byte(8'hA0, ack);
    send_byte(8'h0F, ack);
    bus_cond(1'b1, 1'b0);
    send_byte(8'hA1, ack);
    wait_clk(1); m_scl = 1'b0;
    wait_clk(5); mid = 1'b1;
    wait_clk(1); mid = 1'b0;
    wait_clk(2);
    check("tx_drive_low", bus_if.O_SDA, 0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_sda", bus_if.O_SDA, 1);
    check("async_rst_busy", bus_if.O_BUSY, 0);
    check("async_rst_rw", bus_if.O_RW, 0);
    check("async_rst_addr", bus_if.O_REG_ADDR, 0);
    check("async_rst_wdata", bus_if.O_REG_WDATA, 0);
    check("async_rst_ack_mstr", bus_if.O_ACK_MSTR, 0);
    wait_clk(3);
    rst_n = 1'b1;
    m_scl = 1'b1;
    m_sda = 1'b1;
    wait_clk(10);
    ref_ptr = 0;
    ref_rw  = 1'b0;
    wr_q = '{8'hE1, 8'h1E};
    do_write(7'h50, 8'h07);

    // Randomised mix of writes (good, foreign address, bad pointer) and reads.
    for (int t = 0; t < 20; t++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if (kind < 7) begin
        logic [6:0] a;
        logic [7:0] p;
        a = (kind == 0) ? (7'h50 ^ 7'($urandom_range(1, 127))) : 7'h50;
        p = (kind == 1) ? 8'($urandom_range(RN, 255)) : 8'($urandom_range(0, RN - 1));
        repeat ($urandom_range(0, 3)) wr_q.push_back(8'($urandom));
        do_write(a, p);
      end else begin
        do_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, RN - 1)),
                int'($urandom_range(1, 3)));
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
